peak_accumulate_framer: RTL



---
 rtl/peak_acc_pkg.sv | 16 +
 rtl/acc_ram_sdp.sv | 21 ++
 rtl/peak_accumulate_framer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/peak_acc_pkg.sv
// peak_acc_pkg: shared state encoding, frame tags and bin address width helper
package peak_acc_pkg;
    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_ACCUM  = 6'b000010,
        S_DRAIN  = 6'b000100,
        S_HEADER = 6'b001000,
        S_DUMP   = 6'b010000,
        S_FOOTER = 6'b100000
    } state_t;
    localparam logic [7:0] HEADER_TAG = 8'hA5;
    localparam logic [7:0] FOOTER_TAG = 8'h5A;
    function automatic int bin_w(input int len);
        return $clog2(len);
    endfunction
endpackage

// File: rtl/acc_ram_sdp.sv
// acc_ram_sdp: simple dual-port accumulator RAM with one-cycle registered read
module acc_ram_sdp
    import peak_acc_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    localparam int AW = bin_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/peak_accumulate_framer.sv
// peak_accumulate_framer: sums thresholded records bin-by-bin and emits header/bins/footer frames
// Optional clamp-at-max arithmetic with overflow flag in footer bit 0: define PEAK_ACC_SATURATE_EN.
module peak_accumulate_framer
    import peak_acc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 16,
    parameter int RECORD_LEN = 256,
    parameter int CNT_W      = 8
) (
    input  logic              SysClk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] InData,
    input  logic              InValid,
    input  logic              InLast,
    output logic              InReady,
    input  logic [DATA_W-1:0] MinLevel,
    input  logic [CNT_W-1:0]  NumRecords,
    input  logic              Abort,
    output logic [ACC_W-1:0]  OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast,
    output logic              Busy,
    output logic              LenError
);
    localparam int AW = bin_w(RECORD_LEN);
    localparam int BW = AW + 1;
    localparam logic [BW-1:0] RL  = BW'(RECORD_LEN);
    localparam logic [BW-1:0] RL1 = BW'(RECORD_LEN - 1);

    state_t            r_state;
    logic [BW-1:0]     r_bin, r_hw, r_fetch;
    logic [CNT_W-1:0]  r_num, r_rec;
    logic              r_pend_v, r_pend_zero, r_byp, r_dv, r_ov, r_last, r_len_err;
    logic [AW-1:0]     r_pend_addr;
    logic [ACC_W-1:0]  r_pend_val, r_byp_val, r_out;

    logic              w_acc, w_take, w_in_range, w_load, w_xfer, w_ovf_bit;
    logic [BW-1:0]     w_len, w_hw_next, w_fdata;
    logic [CNT_W-1:0]  w_num_in, w_num, w_rec_next;
    logic [ACC_W-1:0]  w_contrib, w_rdata, w_opnd, w_wdata;
    logic [AW-1:0]     w_raddr;

    assign w_acc      = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_take     = InValid && w_acc;
    assign w_in_range = r_bin < RL;
    assign w_contrib  = (InData >= MinLevel) ? ACC_W'(InData) : '0;
    assign w_num_in   = (NumRecords == '0) ? CNT_W'(1) : NumRecords;
    assign w_num      = (r_state == S_IDLE) ? w_num_in : r_num;
    assign w_rec_next = r_rec + 1'b1;
    assign w_len      = w_in_range ? r_bin + 1'b1 : r_bin;
    // r_hw marks how many low bins this batch has written; anything above it reads as zero
    assign w_hw_next  = ((r_rec == '0) || (w_len > r_hw)) ? w_len : r_hw;
    assign w_opnd     = r_pend_zero ? '0 : (r_byp ? r_byp_val : w_rdata);
    assign w_xfer     = r_ov && OutReady;
    assign w_load     = (r_state == S_DUMP) && r_dv && (!r_ov || OutReady);
    assign w_fdata    = w_load ? r_fetch + 1'b1 : r_fetch;
    assign w_raddr    = (r_state == S_DUMP) ? w_fdata[AW-1:0] : r_bin[AW-1:0];

`ifdef PEAK_ACC_SATURATE_EN
    logic [ACC_W:0] w_sum;
    logic           r_ovf;
    assign w_sum     = {1'b0, w_opnd} + {1'b0, r_pend_val};
    assign w_wdata   = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign w_ovf_bit = r_ovf;
    always_ff @(posedge SysClk) begin
        if (Reset || Abort || (w_take && r_state == S_IDLE)) r_ovf <= 1'b0;
        else if (r_pend_v && w_sum[ACC_W]) r_ovf <= 1'b1;
    end
`else
    assign w_wdata   = w_opnd + r_pend_val;
    assign w_ovf_bit = 1'b0;
`endif

    acc_ram_sdp #(.DEPTH(RECORD_LEN), .WIDTH(ACC_W)) u_ram (
        .i_clk  (SysClk),
        .i_we   (r_pend_v),
        .i_waddr(r_pend_addr),
        .i_wdata(w_wdata),
        .i_raddr(w_raddr),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_bin       <= '0;
            r_hw        <= '0;
            r_fetch     <= '0;
            r_num       <= '0;
            r_rec       <= '0;
            r_pend_v    <= 1'b0;
            r_pend_zero <= 1'b0;
            r_pend_addr <= '0;
            r_pend_val  <= '0;
            r_byp       <= 1'b0;
            r_byp_val   <= '0;
            r_dv        <= 1'b0;
            r_ov        <= 1'b0;
            r_last      <= 1'b0;
            r_out       <= '0;
            r_len_err   <= 1'b0;
        end else if (Abort) begin
            r_state  <= S_IDLE;
            r_bin    <= '0;
            r_hw     <= '0;
            r_fetch  <= '0;
            r_num    <= '0;
            r_rec    <= '0;
            r_pend_v <= 1'b0;
            r_byp    <= 1'b0;
            r_dv     <= 1'b0;
            r_ov     <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            r_pend_v    <= w_take && w_in_range;
            r_pend_addr <= r_bin[AW-1:0];
            r_pend_val  <= w_contrib;
            r_pend_zero <= (r_rec == '0) || (r_bin >= r_hw);
            // a read that collides with this cycle's write takes the written value next cycle
            r_byp       <= r_pend_v && (r_pend_addr == w_raddr);
            r_byp_val   <= w_wdata;
            if (w_take && (InLast ? r_bin < RL1 : r_bin == RL1)) r_len_err <= 1'b1;
            case (r_state)
                S_IDLE, S_ACCUM: if (w_take) begin
                    if (r_state == S_IDLE) r_num <= w_num_in;
                    r_state <= (InLast && w_rec_next == w_num) ? S_DRAIN : S_ACCUM;
                    r_bin   <= InLast ? '0 : w_len;
                    if (InLast) begin
                        r_hw  <= w_hw_next;
                        r_rec <= (w_rec_next == w_num) ? '0 : w_rec_next;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_HEADER;
                    r_out   <= {HEADER_TAG, (ACC_W-8)'(r_num)};
                    r_ov    <= 1'b1;
                end
                S_HEADER: if (OutReady) begin
                    r_state <= S_DUMP;
                    r_ov    <= 1'b0;
                    r_fetch <= '0;
                    r_dv    <= 1'b0;
                end
                S_DUMP: begin
                    r_fetch <= w_fdata;
                    r_dv    <= w_fdata < RL;
                    if (w_load) begin
                        r_out <= (r_fetch < r_hw) ? w_rdata : '0;
                        r_ov  <= 1'b1;
                    end else if (w_xfer && r_fetch == RL) begin
                        r_out   <= {FOOTER_TAG, (ACC_W-8)'(w_ovf_bit)};
                        r_last  <= 1'b1;
                        r_state <= S_FOOTER;
                    end else if (w_xfer) begin
                        r_ov <= 1'b0;
                    end
                end
                S_FOOTER: if (OutReady) begin
                    r_state <= S_IDLE;
                    r_ov    <= 1'b0;
                    r_last  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign InReady  = w_acc && !Reset;
    assign OutData  = r_out;
    assign OutValid = r_ov;
    assign OutLast  = r_last;
    assign Busy     = r_state != S_IDLE;
    assign LenError = r_len_err;
endmodule
